// File: rtl/count_capture_fifo_if.sv
// Capture-FIFO bus: counter input, async capture event, overflow clear and the valid/ready drain port.
// The slave modport is the FIFO side; the master modport is the producer/consumer side.
interface count_capture_fifo_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]        count;
    logic                    capture;
    logic                    clear_ovf;
    logic                    out_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [$clog2(DEPTH):0]  level;
    logic                    overflow;

    modport master (
        output count, capture, clear_ovf, out_ready,
        input  out_valid, out_data, level, overflow
    );

    modport slave (
        input  count, capture, clear_ovf, out_ready,
        output out_valid, out_data, level, overflow
    );
endinterface

// File: rtl/count_capture_fifo.sv
// Timestamps synchronized rising edges of capture with the counter value and queues them for a reader.
// Latency: capture sampled -> out_valid after 3 edges; drain is valid/ready, events arriving when full are dropped and flag overflow.
module count_capture_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    count_capture_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic             s1_q, s2_q, s3_q;
    logic             evt;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty, full, pop, push, drop;

    assign evt   = s2_q & ~s3_q;
    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    assign pop   = ~empty & bus.out_ready;
    // A pop frees the slot this same edge, so a full FIFO still accepts the event.
    assign push  = evt & (~full | pop);
    assign drop  = evt & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = drop | (ovf_q & ~bus.clear_ovf);
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            s1_q     <= bus.capture;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: entries are only visible through level.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.count;
    end

    assign bus.out_valid = ~empty;
    assign bus.out_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.level     = level_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: doc/count_capture_fifo.md
# count_capture_fifo

Downstream consumer of the free-running clock counter: timestamps external capture events with the current counter value and buffers the results for a slower reader. Each rising edge on the asynchronous `capture` input is synchronized and edge-detected. It then latches the `count` value from the counter stage into a small FIFO. The FIFO is drained through a valid/ready handshake, and lost events are flagged.

## Interface
- `WIDTH`, default 4: width of the counter value being captured.
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low reset. Assertion immediately clears all state; deassertion is synchronous to `clk`.
- `count`  in  WIDTH: counter value from the upstream counter, sampled as-is.
- `capture`  in  1: asynchronous event input; each rising edge is one event.
- `clear_ovf`  in  1: synchronous clear of `overflow`.
- `out_ready`  in  1: consumer accepts the head entry.
- `out_valid`  out  1: FIFO non-empty.
- `out_data`  out  WIDTH: head entry; 0 when empty.
- `level`  out  $clog2(DEPTH)+1: number of stored entries, 0..DEPTH.
- `overflow`  out  1: sticky; set when an event is dropped.

## Operation
- **Synchronizer:** registers s1 <= capture, s2 <= s1, s3 <= s2. `evt = s2 & ~s3`, a one-cycle pulse per rising edge of `capture`.
- **Capture pulse width:** `capture` must be high for at least 2 cycles and low for at least 2 cycles between events. Shorter pulses may be missed; this is not an error.
- **Push:** when `evt` is high, the `count` value present at that clock edge is written at the write pointer.
- **Pop:** when `out_valid & out_ready` at an edge, the read pointer advances.
- **Pointers:** read and write pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. `level` is tracked separately: +1 on push only, -1 on pop only, unchanged on both or neither.
- **Full, push without pop:** the event is dropped, storage and pointers are unchanged, and `overflow` is set.
- **Full, push and pop in the same cycle:** both happen; `level` stays DEPTH; no overflow.
- **Empty, push:** entry is written; `out_valid` rises the next cycle. There is no same-cycle bypass, so a pop can never occur while empty.
- **Overflow flag:** `clear_ovf` clears `overflow` at the next edge. If an overflow drop occurs in the same cycle, set wins.
- **Count wrap-around:** `count` is stored verbatim, including wrap from 2^WIDTH-1 to 0. The block does no arithmetic on it.
- **Reset values:** s1/s2/s3 = 0, pointers = 0, `level` = 0, `out_valid` = 0, `out_data` = 0, `overflow` = 0. Storage contents are don't-care.
- **Reset mid-operation:** all entries are discarded and the FIFO is empty the cycle after release.
- **`capture` high at reset release:** the synchronizer starts at 0, so this produces exactly one event about 2 cycles after release.

## Timing
- `capture` rises and is sampled at edge N:
  - s1 = 1 after N.
  - s2 = 1 after N+1, so `evt` is high during cycle N+1..N+2.
  - The `count` value at edge N+2 is stored.
  - `out_valid` = 1 after N+2 if the FIFO was empty.
  - Latency from sampling to valid is 3 edges.
- `out_data`, `out_valid` and `level` all reflect the post-edge state.
- `out_data` changes to the next entry in the same cycle the pop takes effect.
- Sustained throughput is one pop per cycle. Pushes are limited to one per 4 cycles by the pulse-width rule.
- `overflow` asserts one edge after the dropped `evt`.

## Test plan
1. **Reset:** assert `reset` low mid-simulation with 2 entries stored -> all outputs 0 immediately; after release, `level` = 0, `out_valid` = 0.
2. **Single capture:** with WIDTH=4 and the counter incrementing each cycle, raise `capture` at a clk edge where `count` = 3 -> after 3 edges `out_valid` = 1 and `out_data` = 5 (value at edge N+2); `level` = 1; with `out_ready` = 1, empty the next cycle.
3. **Fill and overflow:** with `out_ready` = 0, send 5 captures (DEPTH=4) -> `level` = 4 after the 4th; the 5th is dropped and `overflow` = 1; drain returns the first 4 count values in order.
4. **Full, simultaneous push/pop:** with `level` = 4, a 5th event coincides with `out_ready` = 1 -> `level` stays 4, `overflow` stays 0, the oldest entry is popped, and the new value lands at the tail.
5. **Overflow clear vs set:** pulse `clear_ovf` in the same cycle as a dropped event -> `overflow` stays 1; pulse it alone -> `overflow` = 0 next cycle.
6. **Wrap and short pulse:** capture when `count` wraps 15 -> 0 -> the stored value is 0 or 15 exactly as sampled. A 1-cycle `capture` glitch is not required to capture, but it must never produce 2 entries.
